image_capture_writer: RTL and testbench

//  Downstream consumer of image_capture_manager's image_capture_enabled / clear_memory controls.

---
 rtl/image_capture_writer_pkg.sv | 16 +
 rtl/pixel_pair_packer.sv | 66 ++++++
 rtl/image_capture_writer.sv | 158 +++++++++++++++
 tb/tb_image_capture_writer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_capture_writer_pkg.sv
// rtl/image_capture_writer_pkg.sv - FSM states and default sizes shared by the capture writer
package image_capture_writer_pkg;

    localparam int DEFAULT_PIXEL_WIDTH = 8;
    localparam int DEFAULT_MEM_DEPTH   = 76800;
    localparam int DEFAULT_ADDR_WIDTH  = 17;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_CAPTURE    = 3'd2,
        ST_DONE       = 3'd3,
        ST_CLEARING   = 3'd4
    } state_t;

endpackage

// File: rtl/pixel_pair_packer.sv
// rtl/pixel_pair_packer.sv - pairs camera bytes into words, flushing half pairs at line or frame end
module pixel_pair_packer #(
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     active,
    input  logic                     href,
    input  logic                     pixel_valid,
    input  logic [PIXEL_WIDTH-1:0]   pixel_data,
    input  logic                     frame_end,
    input  logic                     accept,
    output logic                     emit,
    output logic                     word_valid,
    output logic [2*PIXEL_WIDTH-1:0] word
);

    logic                     have_half;
    logic [PIXEL_WIDTH-1:0]   hi_byte;
    logic                     href_q;
    logic                     sample;
    logic                     href_fall;
    logic [2*PIXEL_WIDTH-1:0] emit_word;

    assign sample    = href & pixel_valid;
    assign href_fall = href_q & ~href;

    // A byte sampled together with the frame end still lands in the last word.
    always_comb begin
        emit      = 1'b0;
        emit_word = '0;
        if (active) begin
            if (sample && have_half) begin
                emit      = 1'b1;
                emit_word = {hi_byte, pixel_data};
            end else if (sample && frame_end) begin
                emit      = 1'b1;
                emit_word = {pixel_data, {PIXEL_WIDTH{1'b0}}};
            end else if (!sample && have_half && (href_fall || frame_end)) begin
                emit      = 1'b1;
                emit_word = {hi_byte, {PIXEL_WIDTH{1'b0}}};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_half  <= 1'b0;
            hi_byte    <= '0;
            href_q     <= 1'b0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            href_q     <= href;
            word_valid <= emit & accept;
            word       <= (emit && accept) ? emit_word : '0;
            if (!active || emit) begin
                have_half <= 1'b0;
            end else if (sample) begin
                have_half <= 1'b1;
                hi_byte   <= pixel_data;
            end
        end
    end

endmodule

// File: rtl/image_capture_writer.sv
// rtl/image_capture_writer.sv - writes packed camera frames to frame memory and zero-fills it on request
module image_capture_writer
    import image_capture_writer_pkg::*;
#(
    parameter int PIXEL_WIDTH    = DEFAULT_PIXEL_WIDTH,
    parameter int MEM_DATA_WIDTH = 2 * DEFAULT_PIXEL_WIDTH,
    parameter int MEM_DEPTH      = DEFAULT_MEM_DEPTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      enable,
    input  logic                      clear_memory,
    input  logic                      vsync,
    input  logic                      href,
    input  logic                      pixel_valid,
    input  logic [PIXEL_WIDTH-1:0]    pixel_data,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_wdata,
    output logic                      mem_we,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overflow,
    output logic [15:0]               frame_count,
    output logic [ADDR_WIDTH:0]       words_written
);

    localparam int              CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   DEPTH = CW'(MEM_DEPTH);

    state_t          state;
    logic            vsync_q;
    logic            clear_q;
    logic [CW-1:0]   addr;
    logic            clear_we;
    logic            vsync_fall;
    logic            vsync_rise;
    logic            clear_rise;
    logic            active;
    logic            accept;
    logic            emit;
    logic            wr;
    logic            word_valid;

    assign vsync_fall = vsync_q & ~vsync;
    assign vsync_rise = ~vsync_q & vsync;
    assign clear_rise = clear_memory & ~clear_q;
    // Any abort event in this cycle stops sampling so nothing of the aborted frame is written.
    assign active     = (state == ST_CAPTURE) && enable && !clear_rise;
    assign accept     = (addr != DEPTH);
    assign wr         = emit & accept;
    assign mem_we     = word_valid | clear_we;

    pixel_pair_packer #(
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_packer (
        .clk         (aclk),
        .rst         (areset),
        .active      (active),
        .href        (href),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .frame_end   (vsync_rise),
        .accept      (accept),
        .emit        (emit),
        .word_valid  (word_valid),
        .word        (mem_wdata)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= ST_IDLE;
            vsync_q       <= 1'b0;
            clear_q       <= 1'b0;
            addr          <= '0;
            mem_addr      <= '0;
            clear_we      <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            frame_count   <= '0;
            words_written <= '0;
        end else begin
            vsync_q    <= vsync;
            clear_q    <= clear_memory;
            frame_done <= 1'b0;
            clear_we   <= 1'b0;
            if (clear_rise && state != ST_CLEARING) begin
                state    <= ST_CLEARING;
                busy     <= 1'b1;
                clear_we <= 1'b1;
                mem_addr <= '0;
                addr     <= CW'(1);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (enable) begin
                            state <= ST_WAIT_FRAME;
                            busy  <= 1'b1;
                        end
                    end
                    ST_WAIT_FRAME: begin
                        if (!enable) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (vsync_fall) begin
                            state    <= ST_CAPTURE;
                            addr     <= '0;
                            overflow <= 1'b0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (!enable) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            if (wr) begin
                                mem_addr <= addr[ADDR_WIDTH-1:0];
                                addr     <= addr + CW'(1);
                            end else if (emit) begin
                                overflow <= 1'b1;
                            end
                            if (vsync_rise) begin
                                state         <= ST_DONE;
                                frame_done    <= 1'b1;
                                frame_count   <= frame_count + 16'd1;
                                words_written <= addr + CW'(wr);
                            end
                        end
                    end
                    ST_DONE: begin
                        if (enable) begin
                            state <= ST_WAIT_FRAME;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    ST_CLEARING: begin
                        if (addr == DEPTH) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            clear_we <= 1'b1;
                            mem_addr <= addr[ADDR_WIDTH-1:0];
                            addr     <= addr + CW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_image_capture_writer.sv
// tb/tb_image_capture_writer.sv - randomized scoreboard bench for image_capture_writer
module tb_image_capture_writer;

    localparam int PW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 40;
    localparam int AW    = 6;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          enable = 1'b0;
    logic          clear_memory = 1'b0;
    logic          vsync = 1'b1;
    logic          href = 1'b0;
    logic          pixel_valid = 1'b0;
    logic [PW-1:0] pixel_data = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          busy;
    logic          frame_done;
    logic          overflow;
    logic [15:0]   frame_count;
    logic [AW:0]   words_written;

    image_capture_writer #(
        .PIXEL_WIDTH    (PW),
        .MEM_DATA_WIDTH (DW),
        .MEM_DEPTH      (DEPTH),
        .ADDR_WIDTH     (AW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .enable        (enable),
        .clear_memory  (clear_memory),
        .vsync         (vsync),
        .href          (href),
        .pixel_valid   (pixel_valid),
        .pixel_data    (pixel_data),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .busy          (busy),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .frame_count   (frame_count),
        .words_written (words_written)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [AW:0]   ww;
        logic [15:0]   fc;
        logic          ov;
    } done_t;

    wr_t   wr_q[$];
    done_t done_q[$];
    int    tests = 0;
    int    fails = 0;
    bit    mon_en = 1'b0;
    int    model_fc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (mon_en && !areset) begin
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("write_addr", mem_addr, e.addr);
                    check("write_data", mem_wdata, e.data);
                end
            end
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame_done: count 0x%0h, expected no pulse", frame_count);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("words_written", words_written, d.ww);
                    check("frame_count", frame_count, d.fc);
                    check("overflow_at_done", overflow, d.ov);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Reference: each line pairs bytes high-then-low, an odd tail gets a zero low byte,
    // words go to consecutive addresses and anything past DEPTH is dropped.
    task automatic expect_frame(input logic [7:0] bytes[$], input int lens[$], input bit complete);
        logic [15:0] words[$];
        int p = 0;
        foreach (lens[l]) begin
            for (int i = 0; i < lens[l]; i += 2) begin
                if (i + 1 < lens[l]) words.push_back({bytes[p+i], bytes[p+i+1]});
                else                 words.push_back({bytes[p+i], 8'h00});
            end
            p += lens[l];
        end
        foreach (words[k]) begin
            if (k < DEPTH) wr_q.push_back('{addr: AW'(k), data: words[k]});
        end
        if (complete) begin
            model_fc++;
            done_q.push_back('{ww: (AW+1)'((words.size() < DEPTH) ? words.size() : DEPTH),
                               fc: 16'(model_fc),
                               ov: (words.size() > DEPTH)});
        end
    endtask

    task automatic gen(input int nl, input int lo, input int hi, output logic [7:0] bytes[$], output int lens[$]);
        bytes.delete();
        lens.delete();
        for (int l = 0; l < nl; l++) begin
            int n;
            n = $urandom_range(lo, hi);
            lens.push_back(n);
            for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
        end
    endtask

    task automatic drive_bytes(input logic [7:0] bytes[$], input int lens[$], input bit vs_last);
        int p = 0;
        foreach (lens[l]) begin
            href = 1'b1;
            for (int i = 0; i < lens[l]; i++) begin
                pixel_valid = 1'b0;
                tick($urandom_range(0, 2));
                pixel_valid = 1'b1;
                pixel_data  = bytes[p+i];
                if (vs_last && l == lens.size() - 1 && i == lens[l] - 1) vsync = 1'b1;
                tick(1);
            end
            pixel_valid = 1'b0;
            href        = 1'b0;
            p += lens[l];
            tick(2);
        end
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(2);
    endtask

    task automatic run_frame(input logic [7:0] bytes[$], input int lens[$], input bit vs_last);
        expect_frame(bytes, lens, 1'b1);
        frame_start();
        drive_bytes(bytes, lens, vs_last);
        vsync = 1'b1;
        tick(4);
    endtask

    initial begin
        logic [7:0] b[$];
        int         lens[$];
        int         bad;

        #12;
        check("reset_mem_we", mem_we, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_count", frame_count, 0);
        tick(1);
        areset = 1'b0;
        mon_en = 1'b1;
        enable = 1'b1;
        tick(2);
        check("idle_to_wait_busy", busy, 1);

        // 4 lines x 8 bytes of 0x01..0x20
        b.delete();
        lens = '{8, 8, 8, 8};
        for (int i = 1; i <= 32; i++) b.push_back(8'(i));
        run_frame(b, lens, 1'b0);
        check("frame1_count", frame_count, 1);
        check("frame1_words", words_written, 16);

        // odd line: flush of 0xA500 one cycle after href falls
        b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        lens = '{5};
        expect_frame(b, lens, 1'b1);
        frame_start();
        href = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = b[i];
            tick(1);
        end
        pixel_valid = 1'b0;
        href        = 1'b0;
        tick(1);
        check("flush_we", mem_we, 1);
        check("flush_addr", mem_addr, 2);
        check("flush_data", mem_wdata, 16'hA500);
        tick(2);
        vsync = 1'b1;
        tick(4);

        // asynchronous reset in the middle of a capture
        check("pre_reset_wq_empty", wr_q.size(), 0);
        mon_en = 1'b0;
        frame_start();
        href        = 1'b1;
        pixel_valid = 1'b1;
        pixel_data  = 8'h5A;
        tick(3);
        #2 areset = 1'b1;
        #1;
        check("async_reset_mem_we", mem_we, 0);
        check("async_reset_mem_addr", mem_addr, 0);
        check("async_reset_mem_wdata", mem_wdata, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_frame_count", frame_count, 0);
        check("async_reset_words_written", words_written, 0);
        @(posedge aclk);
        #1;
        areset      = 1'b0;
        href        = 1'b0;
        pixel_valid = 1'b0;
        vsync       = 1'b1;
        model_fc    = 0;
        mon_en      = 1'b1;
        tick(1);
        check("post_reset_busy", busy, 1);

        // overflow: 48 words into a 40-word memory, cleared at the next frame start
        gen(6, 16, 16, b, lens);
        run_frame(b, lens, 1'b0);
        check("overflow_sticky", overflow, 1);
        gen(1, 1, 6, b, lens);
        expect_frame(b, lens, 1'b1);
        frame_start();
        check("overflow_cleared", overflow, 0);
        drive_bytes(b, lens, 1'b0);
        vsync = 1'b1;
        tick(4);

        // clear rise mid-capture, second rise during the fill is ignored
        gen(2, 1, 9, b, lens);
        expect_frame(b, lens, 1'b0);
        frame_start();
        drive_bytes(b, lens, 1'b0);
        for (int k = 0; k < DEPTH; k++) wr_q.push_back('{addr: AW'(k), data: 16'h0000});
        clear_memory = 1'b1;
        tick(1);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_we !== 1'b1 || mem_addr !== AW'(i) || busy !== 1'b1) bad++;
            if (i == 5)  clear_memory = 1'b0;
            if (i == 10) clear_memory = 1'b1;
            tick(1);
        end
        check("clear_consecutive_bad_cycles", bad, 0);
        check("clear_busy_fall", busy, 0);
        check("clear_we_end", mem_we, 0);
        check("clear_frame_count", frame_count, model_fc);
        clear_memory = 1'b0;
        vsync        = 1'b1;
        tick(3);

        // enable dropped mid-frame, then re-enabled while vsync is still low
        gen(1, 2, 9, b, lens);
        expect_frame(b, lens, 1'b0);
        frame_start();
        drive_bytes(b, lens, 1'b0);
        enable = 1'b0;
        tick(1);
        check("enable_drop_busy", busy, 0);
        gen(1, 2, 9, b, lens);
        drive_bytes(b, lens, 1'b0);
        enable = 1'b1;
        tick(2);
        gen(1, 2, 9, b, lens);
        drive_bytes(b, lens, 1'b0);
        check("enable_drop_frame_count", frame_count, model_fc);
        gen(2, 1, 9, b, lens);
        run_frame(b, lens, 1'b0);

        // byte sampled in the same cycle vsync rises
        gen(2, 3, 3, b, lens);
        run_frame(b, lens, 1'b1);

        for (int f = 0; f < 6; f++) begin
            gen($urandom_range(1, 4), 1, 9, b, lens);
            run_frame(b, lens, 1'($urandom_range(0, 1)));
        end

        tick(5);
        check("write_queue_drained", wr_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
